// File: rtl/srl_fifo_pkg.sv
// Shared defaults and width helpers for the SRL-based FIFO.
package srl_fifo_pkg;

    localparam int unsigned DEF_W = 8;
    localparam int unsigned DEF_N = 16;

    // Address width of the dynamic tap for a given depth (at least 1 bit).
    function automatic int unsigned tap_aw(input int unsigned depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/srl_tap.sv
// W-bit, N-deep shift register with enable and dynamic read tap; no reset so it
// maps onto SRL16/SRL32 primitives.
module srl_tap
    import srl_fifo_pkg::*;
#(
    parameter int unsigned W  = DEF_W,
    parameter int unsigned N  = DEF_N,
    parameter int unsigned AW = tap_aw(N)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [W-1:0]  d,
    input  logic [AW-1:0] addr,
    output logic [W-1:0]  q
);

    logic [W-1:0] mem [N];

    // Shift new data in at index 0 on every enabled cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= d;
            for (int unsigned k = 1; k < N; k++) begin
                mem[k] <= mem[k-1];
            end
        end
    end

    // Dynamic tap read.
    assign q = mem[addr];

endmodule

// File: rtl/srl_fifo.sv
// Synchronous first-word-fall-through FIFO: shift-register storage read through
// a tap at count-1, so the oldest entry is always on dout.
module srl_fifo
    import srl_fifo_pkg::*;
#(
    parameter int unsigned W = DEF_W,
    parameter int unsigned N = DEF_N
) (
    input  logic                     clk,
    input  logic                     r,
    input  logic [W-1:0]             din,
    input  logic                     we,
    output logic                     full,
    input  logic                     re,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic [$clog2(N+1)-1:0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int unsigned CW = $clog2(N+1);
    localparam int unsigned AW = tap_aw(N);

    logic          push_c;
    logic          pop_c;
    logic          shift_c;
    logic [CW-1:0] count_nxt;
    logic          ovf_nxt;
    logic          udf_nxt;
    logic [CW-1:0] last_c;
    logic [AW-1:0] tap_addr_c;

    // Flags come straight from the registered occupancy.
    assign full  = (count == CW'(N));
    assign empty = (count == '0);

    // Tap tracks the oldest entry; its value while empty is don't-care.
    assign last_c     = count - CW'(1);
    assign tap_addr_c = AW'(last_c);

    // Accept logic and next occupancy/flag state.
    always_comb begin
        push_c    = 1'b0;
        pop_c     = 1'b0;
        shift_c   = 1'b0;
        count_nxt = count;
        ovf_nxt   = ovf;
        udf_nxt   = udf;

        push_c  = we && (!full || re);
        pop_c   = re && !empty;
        shift_c = push_c && !r;

        if (push_c && !pop_c) begin
            count_nxt = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_nxt = count - CW'(1);
        end

        if (we && !push_c) begin
            ovf_nxt = 1'b1;
        end
        if (re && !pop_c) begin
            udf_nxt = 1'b1;
        end
    end

    // Occupancy and sticky error flags; reset wins over push/pop.
    always_ff @(posedge clk) begin
        if (r) begin
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else begin
            count <= count_nxt;
            ovf   <= ovf_nxt;
            udf   <= udf_nxt;
        end
    end

    srl_tap #(
        .W  (W),
        .N  (N),
        .AW (AW)
    ) u_tap (
        .clk  (clk),
        .en   (shift_c),
        .d    (din),
        .addr (tap_addr_c),
        .q    (dout)
    );

endmodule

// File: tb/tb_srl_fifo.sv
// Self-checking bench for srl_fifo: queue-based reference model compared every
// cycle, plus directed literal expectations.
module tb_srl_fifo;

    localparam int unsigned W  = 8;
    localparam int unsigned N  = 16;
    localparam int unsigned CW = $clog2(N+1);

    logic          clk;
    logic          r;
    logic [W-1:0]  din;
    logic          we;
    logic          re;
    logic          full;
    logic          empty;
    logic [W-1:0]  dout;
    logic [CW-1:0] count;
    logic          ovf;
    logic          udf;

    srl_fifo #(.W(W), .N(N)) dut (
        .clk   (clk),
        .r     (r),
        .din   (din),
        .we    (we),
        .full  (full),
        .re    (re),
        .dout  (dout),
        .empty (empty),
        .count (count),
        .ovf   (ovf),
        .udf   (udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: queue front is the oldest entry.
    logic [W-1:0] mq [$];
    logic         m_ovf;
    logic         m_udf;
    bit           checking;

    int nchecks;
    int nerrors;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string name, input logic [31:0] dut_v,
                       input logic [31:0] mdl_v, input logic [31:0] exp);
        chk({"dut_", name}, dut_v, exp);
        chk({"mdl_", name}, mdl_v, exp);
    endtask

    // Apply one cycle of inputs and advance the model at the clock edge.
    task automatic step(input logic r_i, input logic we_i, input logic re_i,
                        input logic [W-1:0] d_i);
        bit do_push;
        bit do_pop;
        r   = r_i;
        we  = we_i;
        re  = re_i;
        din = d_i;
        @(posedge clk);
        if (r_i) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            do_push = we_i && ((mq.size() < N) || re_i);
            do_pop  = re_i && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(d_i);
            if (we_i && !do_push) m_ovf = 1'b1;
            if (re_i && !do_pop)  m_udf = 1'b1;
        end
        checking = 1'b1;
        #1;
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (checking) begin
            chk("count", 32'(count), 32'(mq.size()));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full",  32'(full),  32'(mq.size() == N));
            chk("ovf",   32'(ovf),   32'(m_ovf));
            chk("udf",   32'(udf),   32'(m_udf));
            if (mq.size() > 0) chk("dout", 32'(dout), 32'(mq[0]));
        end
    end

    initial begin
        nchecks  = 0;
        nerrors  = 0;
        checking = 1'b0;
        m_ovf    = 1'b0;
        m_udf    = 1'b0;
        r = 1'b0; we = 1'b0; re = 1'b0; din = '0;

        // Reset.
        step(1, 0, 0, 8'h00);
        lit("rst_count", 32'(count), 32'(mq.size()), 0);
        lit("rst_empty", 32'(empty), 32'(mq.size() == 0), 1);
        lit("rst_full",  32'(full),  32'(mq.size() == N), 0);
        lit("rst_ovf",   32'(ovf),   32'(m_ovf), 0);
        lit("rst_udf",   32'(udf),   32'(m_udf), 0);

        // Fill 0x01..0x10.
        for (int i = 1; i <= 16; i++) step(0, 1, 0, 8'(i));
        lit("fill_full",  32'(full),  32'(mq.size() == N), 1);
        lit("fill_count", 32'(count), 32'(mq.size()), 16);
        lit("fill_dout",  32'(dout),  32'(mq[0]), 8'h01);

        // Overflow push.
        step(0, 1, 0, 8'hAA);
        lit("ovf_flag",  32'(ovf),   32'(m_ovf), 1);
        lit("ovf_count", 32'(count), 32'(mq.size()), 16);

        // Drain in order.
        for (int i = 1; i <= 16; i++) begin
            lit("drain_dout", 32'(dout), 32'(mq[0]), 32'(i));
            step(0, 0, 1, 8'h00);
        end
        lit("drain_empty", 32'(empty), 32'(mq.size() == 0), 1);
        lit("drain_ovf",   32'(ovf),   32'(m_ovf), 1);

        // Underflow, then push+pop while empty.
        step(0, 0, 1, 8'h00);
        lit("udf_flag",  32'(udf),   32'(m_udf), 1);
        lit("udf_count", 32'(count), 32'(mq.size()), 0);
        step(0, 1, 1, 8'h5A);
        lit("wr_empty_count", 32'(count), 32'(mq.size()), 1);
        lit("wr_empty_dout",  32'(dout),  32'(mq[0]), 8'h5A);

        // Simultaneous push+pop mid-fill.
        step(1, 0, 0, 8'h00);
        step(0, 1, 0, 8'h11);
        step(0, 1, 0, 8'h22);
        step(0, 1, 0, 8'h33);
        step(0, 1, 1, 8'h44);
        lit("pp_dout",  32'(dout),  32'(mq[0]), 8'h22);
        lit("pp_count", 32'(count), 32'(mq.size()), 3);

        // Simultaneous push+pop while full.
        for (int i = 0; i < 13; i++) step(0, 1, 0, 8'(8'hC0 + i));
        lit("pf_pre_full", 32'(full), 32'(mq.size() == N), 1);
        step(0, 1, 1, 8'hEE);
        lit("pf_count", 32'(count), 32'(mq.size()), 16);
        lit("pf_ovf",   32'(ovf),   32'(m_ovf), 0);
        lit("pf_dout",  32'(dout),  32'(mq[0]), 8'h33);

        // Reset mid-operation with a push requested.
        step(1, 0, 0, 8'h00);
        for (int i = 0; i < 7; i++) step(0, 1, 0, 8'(8'h70 + i));
        lit("mid_count7", 32'(count), 32'(mq.size()), 7);
        step(1, 1, 0, 8'h99);
        lit("mid_count", 32'(count), 32'(mq.size()), 0);
        lit("mid_empty", 32'(empty), 32'(mq.size() == 0), 1);
        lit("mid_ovf",   32'(ovf),   32'(m_ovf), 0);
        lit("mid_udf",   32'(udf),   32'(m_udf), 0);
        step(0, 1, 0, 8'h55);
        lit("mid_dout", 32'(dout), 32'(mq[0]), 8'h55);

        // Random traffic, model-checked every cycle.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0,
                 8'($urandom));
        end

        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
